// File: rtl/sysarr_out_fifo_drain.sv
// ---------------------------------------------------------------------------
// sysarr_out_fifo_drain
//
// Output buffer for one systolic-array output column. Each cycle it can
// capture one DW-bit result into a DEPTH-entry shift register, where
// entry 0 is the newest word. All entries are visible in parallel. The
// buffer tracks how many entries are valid and offers a ready/valid drain
// port that pops the oldest valid entry, entry[count-1].
//
// Ports:
//   clk          rising-edge clock
//   nRST         asynchronous active-low reset
//   shift        push shift_value this cycle
//   shift_value  data word from the array edge
//   clear        synchronous flush; overrides shift and drain_ready
//   drain_ready  consumer accepts drain_data this cycle
//   drain_valid  oldest entry available (count != 0)
//   drain_data   oldest valid entry, or 0 when the buffer is empty
//   out          parallel view, out[DW*i +: DW] = entry[i]
//   valid_mask   bit i is set when i < count
//   count        occupancy, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
//   overflow     sticky; set by a push while full that has no pop
// ---------------------------------------------------------------------------
module sysarr_out_fifo_drain #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  shift,
    input  logic [DW-1:0]         shift_value,
    input  logic                  clear,
    input  logic                  drain_ready,
    output logic                  drain_valid,
    output logic [DW-1:0]         drain_data,
    output logic [DW*DEPTH-1:0]   out,
    output logic [DEPTH-1:0]      valid_mask,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [DW-1:0]    entry_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic             overflow_r;

    logic             pop_s;
    logic             nonempty_s;
    logic [DW-1:0]    drain_data_s;
    logic [DEPTH-1:0] valid_mask_s;

    assign nonempty_s = (count_r != '0);
    // A pop needs something to pop. When the buffer is empty, a push in the
    // same cycle is not a bypass, so the new word is not popped.
    assign pop_s      = nonempty_s & drain_ready;

    // Storage, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (shift) begin
                entry_r[0] <= shift_value;
                for (int i = 1; i < DEPTH; i++) begin
                    entry_r[i] <= entry_r[i-1];
                end
            end
            // A push together with a pop leaves count unchanged. The popped
            // word was entry[count-1] before the shift, so nothing valid is
            // lost, even when the buffer is full.
            if (shift && !pop_s) begin
                if (count_r == DEPTH_C) begin
                    overflow_r <= 1'b1;
                end else begin
                    count_r <= count_r + ONE_C;
                end
            end else if (!shift && pop_s) begin
                count_r <= count_r - ONE_C;
            end
        end
    end

    // Oldest-entry mux. The result stays 0 when no entry is valid.
    always_comb begin
        drain_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_r == CW'(i + 1)) begin
                drain_data_s = entry_r[i];
            end else begin
                drain_data_s = drain_data_s;
            end
        end
    end

    // Thermometer mask of valid entries.
    always_comb begin
        valid_mask_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask_s[i] = (CW'(i) < count_r);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_out
            assign out[DW*g +: DW] = entry_r[g];
        end
    endgenerate

    assign drain_valid = nonempty_s;
    assign drain_data  = drain_data_s;
    assign valid_mask  = valid_mask_s;
    assign count       = count_r;
    assign full        = (count_r == DEPTH_C);
    assign empty       = ~nonempty_s;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_sysarr_out_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_sysarr_out_fifo_drain
//
// Testbench for sysarr_out_fifo_drain with DW=16 and DEPTH=4. It applies a
// table of directed vectors and a few hand-written multi-cycle sequences.
// It then runs randomized traffic checked against a queue-based model of
// the buffer.
// ---------------------------------------------------------------------------
module tb_sysarr_out_fifo_drain;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk;
    logic                nRST;
    logic                shift;
    logic [DW-1:0]       shift_value;
    logic                clear;
    logic                drain_ready;
    logic                drain_valid;
    logic [DW-1:0]       drain_data;
    logic [DW*DEPTH-1:0] out;
    logic [DEPTH-1:0]    valid_mask;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                overflow;

    int checks   = 0;
    int failures = 0;

    sysarr_out_fifo_drain #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .shift       (shift),
        .shift_value (shift_value),
        .clear       (clear),
        .drain_ready (drain_ready),
        .drain_valid (drain_valid),
        .drain_data  (drain_data),
        .out         (out),
        .valid_mask  (valid_mask),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed vector: the inputs applied at an edge and the state
    // expected after that edge.
    typedef struct packed {
        logic        s;
        logic [15:0] v;
        logic        c;
        logic        r;
        logic [2:0]  exp_cnt;
        logic [15:0] exp_dd;
        logic        exp_ov;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vq[$];

    // Reference model. The stored words are kept in a list with the newest
    // word first. Occupancy and overflow are tracked as plain numbers.
    logic [15:0] m_q[$];
    int          m_cnt;
    logic        m_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output with the expected occupancy, oldest word,
    // overflow flag and parallel contents. The remaining flags follow from
    // the expected occupancy.
    task automatic check_state(input string tag, input int cnt, input logic [15:0] dd,
                               input logic ov, input logic [63:0] o);
        logic [3:0] mask;
        mask = 4'((5'd1 << cnt) - 5'd1);
        chk({tag, ".count"},       64'(count),       64'(cnt));
        chk({tag, ".drain_data"},  64'(drain_data),  64'(dd));
        chk({tag, ".overflow"},    64'(overflow),    64'(ov));
        chk({tag, ".out"},         out,              o);
        chk({tag, ".full"},        64'(full),        64'(cnt == DEPTH));
        chk({tag, ".empty"},       64'(empty),       64'(cnt == 0));
        chk({tag, ".drain_valid"}, 64'(drain_valid), 64'(cnt != 0));
        chk({tag, ".valid_mask"},  64'(valid_mask),  64'(mask));
    endtask

    task automatic tick(input logic s, input logic [15:0] v, input logic c, input logic r);
        shift       = s;
        shift_value = v;
        clear       = c;
        drain_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_out();
        logic [63:0] o;
        o = 64'h0;
        for (int i = 0; i < DEPTH; i++) begin
            o[16*i +: 16] = m_q[i];
        end
        return o;
    endfunction

    function automatic logic [15:0] model_oldest();
        return (m_cnt == 0) ? 16'h0 : m_q[m_cnt-1];
    endfunction

    task automatic model_reset();
        m_q = {16'h0, 16'h0, 16'h0, 16'h0};
        m_cnt = 0;
        m_ov = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic [15:0] v, input logic c, input logic r);
        bit pop;
        if (c) begin
            model_reset();
        end else begin
            pop = (m_cnt > 0) && r;
            if (s) begin
                m_q.push_front(v);
                void'(m_q.pop_back());
            end
            if (s && !pop) begin
                if (m_cnt == DEPTH) m_ov = 1'b1;
                else m_cnt++;
            end else if (!s && pop) begin
                m_cnt--;
            end
        end
    endtask

    initial begin
        logic        rs, rc, rr;
        logic [15:0] rv;
        logic [15:0] exp_pop;

        nRST = 1'b0;
        shift = 1'b0; shift_value = 16'h0; clear = 1'b0; drain_ready = 1'b0;
        #12;
        check_state("reset", 0, 16'h0, 1'b0, 64'h0);
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;

        // --- directed vector table ---
        vq.push_back('{1'b1, 16'h0123, 1'b0, 1'b0, 3'd1, 16'h0123, 1'b0, 64'h0000_0000_0000_0123});
        vq.push_back('{1'b1, 16'h4567, 1'b0, 1'b0, 3'd2, 16'h0123, 1'b0, 64'h0000_0000_0123_4567});
        vq.push_back('{1'b1, 16'h89AB, 1'b0, 1'b0, 3'd3, 16'h0123, 1'b0, 64'h0000_0123_4567_89AB});
        vq.push_back('{1'b1, 16'hCDEF, 1'b0, 1'b0, 3'd4, 16'h0123, 1'b0, 64'h0123_4567_89AB_CDEF});
        vq.push_back('{1'b1, 16'h1111, 1'b0, 1'b0, 3'd4, 16'h4567, 1'b1, 64'h4567_89AB_CDEF_1111});
        vq.push_back('{1'b1, 16'h2222, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 64'h0});
        vq.push_back('{1'b1, 16'h0123, 1'b0, 1'b0, 3'd1, 16'h0123, 1'b0, 64'h0000_0000_0000_0123});
        vq.push_back('{1'b1, 16'h4567, 1'b0, 1'b0, 3'd2, 16'h0123, 1'b0, 64'h0000_0000_0123_4567});
        vq.push_back('{1'b1, 16'h89AB, 1'b0, 1'b0, 3'd3, 16'h0123, 1'b0, 64'h0000_0123_4567_89AB});
        vq.push_back('{1'b1, 16'hCDEF, 1'b0, 1'b0, 3'd4, 16'h0123, 1'b0, 64'h0123_4567_89AB_CDEF});
        vq.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b1, 3'd3, 16'h4567, 1'b0, 64'h0123_4567_89AB_CDEF});
        vq.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b1, 3'd2, 16'h89AB, 1'b0, 64'h0123_4567_89AB_CDEF});
        vq.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b1, 3'd1, 16'hCDEF, 1'b0, 64'h0123_4567_89AB_CDEF});
        vq.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 64'h0123_4567_89AB_CDEF});
        vq.push_back('{1'b1, 16'hA0A0, 1'b0, 1'b0, 3'd1, 16'hA0A0, 1'b0, 64'h4567_89AB_CDEF_A0A0});
        vq.push_back('{1'b1, 16'hB0B0, 1'b0, 1'b0, 3'd2, 16'hA0A0, 1'b0, 64'h89AB_CDEF_A0A0_B0B0});
        vq.push_back('{1'b1, 16'hC0C0, 1'b0, 1'b1, 3'd2, 16'hB0B0, 1'b0, 64'hCDEF_A0A0_B0B0_C0C0});
        vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'hC0C0, 1'b0, 64'hCDEF_A0A0_B0B0_C0C0});
        vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 64'hCDEF_A0A0_B0B0_C0C0});
        vq.push_back('{1'b1, 16'h5A5A, 1'b0, 1'b1, 3'd1, 16'h5A5A, 1'b0, 64'hA0A0_B0B0_C0C0_5A5A});
        vq.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 3'd2, 16'h5A5A, 1'b0, 64'hB0B0_C0C0_5A5A_0001});
        vq.push_back('{1'b1, 16'h0002, 1'b0, 1'b0, 3'd3, 16'h5A5A, 1'b0, 64'hC0C0_5A5A_0001_0002});
        vq.push_back('{1'b1, 16'h0003, 1'b0, 1'b0, 3'd4, 16'h5A5A, 1'b0, 64'h5A5A_0001_0002_0003});
        vq.push_back('{1'b1, 16'h0004, 1'b0, 1'b1, 3'd4, 16'h0001, 1'b0, 64'h0001_0002_0003_0004});
        vq.push_back('{1'b1, 16'h1111, 1'b0, 1'b0, 3'd4, 16'h0002, 1'b1, 64'h0002_0003_0004_1111});

        for (int k = 0; k < vq.size(); k++) begin
            tick(vq[k].s, vq[k].v, vq[k].c, vq[k].r);
            check_state($sformatf("vec%0d", k), int'(vq[k].exp_cnt), vq[k].exp_dd,
                        vq[k].exp_ov, vq[k].exp_out);
        end

        // --- asynchronous reset in the middle of a cycle, with the buffer
        //     full and overflow set ---
        shift = 1'b0; drain_ready = 1'b0; clear = 1'b0;
        #3;
        nRST = 1'b0;
        #1;
        check_state("async_rst", 0, 16'h0, 1'b0, 64'h0);
        @(negedge clk);
        nRST = 1'b1;
        // The first edge after release accepts a push.
        shift = 1'b1; shift_value = 16'hBEEF;
        @(posedge clk);
        #1;
        check_state("post_rst_push", 1, 16'hBEEF, 1'b0, 64'h0000_0000_0000_BEEF);

        // --- randomized traffic against the model ---
        model_reset();
        m_q.push_front(16'hBEEF);
        void'(m_q.pop_back());
        m_cnt = 1;
        for (int n = 0; n < 600; n++) begin
            rs = 1'($urandom_range(0, 99) < 60);
            rr = 1'($urandom_range(0, 99) < 45);
            rc = 1'($urandom_range(0, 99) < 3);
            rv = 16'($urandom);
            shift = rs; shift_value = rv; clear = rc; drain_ready = rr;
            // Just before the edge, the word offered for a pop is the
            // model's oldest valid word.
            exp_pop = model_oldest();
            chk("rand.pre_drain_data", 64'(drain_data), 64'(exp_pop));
            @(posedge clk);
            #1;
            model_step(rs, rv, rc, rr);
            check_state($sformatf("rand%0d", n), m_cnt, model_oldest(), m_ov, model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
